// File: rtl/stage3_writeback.sv
// Stage 3 of the emulator core: RAM/output-device write requests, next PC and next power/exec-mode flags.
// The datapath is combinational; only the halt status bit is registered.
module stage3_writeback #(
    parameter logic [15:0] RESET_PC = 16'h0044,
    parameter logic [15:0] PC_STEP  = 16'd4
) (
    input  logic        clk,
    input  logic        reset_button,
    input  logic [2:0]  mblock_s3,
    input  logic [31:0] vrw_value,
    input  logic [31:0] vw_value,
    input  logic [7:0]  vrw_source,
    input  logic [15:0] pc,
    input  logic        is_powered_on,
    input  logic        flag_last_zero,
    input  logic        execute_from_ram,
    output logic [31:0] output_devices_value,
    output logic [7:0]  output_devices_address,
    output logic [15:0] ram_address,
    output logic [31:0] ram_in,
    output logic        ram_is_write,
    output logic        output_is_write,
    output logic [15:0] pc_next,
    output logic        execute_from_ram_new,
    output logic        is_powered_on_new,
    output logic        halted
);

    typedef enum logic [2:0] {
        MB_NOP       = 3'd0,
        MB_RAM_DIR   = 3'd1,
        MB_OUT_WRITE = 3'd2,
        MB_RAM_IND   = 3'd3,
        MB_JMP       = 3'd4,
        MB_JZ        = 3'd5,
        MB_JNZ       = 3'd6,
        MB_HLT       = 3'd7
    } mblock_t;

    mblock_t     w_mblock;
    logic [15:0] w_pc_inc;
    logic [15:0] w_target;
    logic        r_halted;

    assign w_mblock = mblock_t'(mblock_s3);
    assign w_pc_inc = pc + PC_STEP;
    assign w_target = vw_value[15:0];

    always_comb begin
        ram_address            = {8'h00, vrw_source};
        ram_in                 = vw_value;
        output_devices_address = vrw_source;
        output_devices_value   = vw_value;
        ram_is_write           = 1'b0;
        output_is_write        = 1'b0;
        pc_next                = w_pc_inc;
        is_powered_on_new      = is_powered_on;
        execute_from_ram_new   = execute_from_ram;

        case (w_mblock)
            MB_NOP:       ;
            MB_RAM_DIR:   ram_is_write = 1'b1;
            MB_OUT_WRITE: output_is_write = 1'b1;
            MB_RAM_IND: begin
                ram_is_write = 1'b1;
                ram_address  = vrw_value[15:0];
            end
            MB_JMP:       pc_next = w_target;
            MB_JZ:        if (flag_last_zero)  pc_next = w_target;
            MB_JNZ:       if (!flag_last_zero) pc_next = w_target;
            MB_HLT: begin
                is_powered_on_new = 1'b0;
                pc_next           = pc;
            end
            default:      ;
        endcase

        // Reset wins over both the powered-off hold and HLT.
        if (reset_button) begin
            ram_is_write         = 1'b0;
            output_is_write      = 1'b0;
            pc_next              = RESET_PC;
            is_powered_on_new    = 1'b1;
            execute_from_ram_new = 1'b0;
        end else if (!is_powered_on) begin
            ram_is_write         = 1'b0;
            output_is_write      = 1'b0;
            pc_next              = pc;
            is_powered_on_new    = 1'b0;
            execute_from_ram_new = execute_from_ram;
        end
    end

    always_ff @(posedge clk or posedge reset_button) begin
        if (reset_button) begin
            r_halted <= 1'b0;
        end else if (w_mblock == MB_HLT && is_powered_on) begin
            r_halted <= 1'b1;
        end
    end

    assign halted = r_halted;

endmodule

// File: tb/tb_stage3_writeback.sv
// Directed self-checking bench for stage3_writeback with hand-computed expectations.
module tb_stage3_writeback;

    logic        clk = 1'b0;
    logic        reset_button;
    logic [2:0]  mblock_s3;
    logic [31:0] vrw_value;
    logic [31:0] vw_value;
    logic [7:0]  vrw_source;
    logic [15:0] pc;
    logic        is_powered_on;
    logic        flag_last_zero;
    logic        execute_from_ram;
    logic [31:0] output_devices_value;
    logic [7:0]  output_devices_address;
    logic [15:0] ram_address;
    logic [31:0] ram_in;
    logic        ram_is_write;
    logic        output_is_write;
    logic [15:0] pc_next;
    logic        execute_from_ram_new;
    logic        is_powered_on_new;
    logic        halted;

    int total = 0;
    int bad   = 0;

    stage3_writeback dut (
        .clk                    (clk),
        .reset_button           (reset_button),
        .mblock_s3              (mblock_s3),
        .vrw_value              (vrw_value),
        .vw_value               (vw_value),
        .vrw_source             (vrw_source),
        .pc                     (pc),
        .is_powered_on          (is_powered_on),
        .flag_last_zero         (flag_last_zero),
        .execute_from_ram       (execute_from_ram),
        .output_devices_value   (output_devices_value),
        .output_devices_address (output_devices_address),
        .ram_address            (ram_address),
        .ram_in                 (ram_in),
        .ram_is_write           (ram_is_write),
        .output_is_write        (output_is_write),
        .pc_next                (pc_next),
        .execute_from_ram_new   (execute_from_ram_new),
        .is_powered_on_new      (is_powered_on_new),
        .halted                 (halted)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Inputs change just after the falling edge so checks land well before the next rising edge.
    task automatic apply(input logic [2:0] mb, input logic [31:0] vrw, input logic [31:0] vw,
                         input logic [7:0] src, input logic [15:0] p, input logic pwr,
                         input logic flag, input logic efr);
        @(negedge clk);
        mblock_s3        = mb;
        vrw_value        = vrw;
        vw_value         = vw;
        vrw_source       = src;
        pc               = p;
        is_powered_on    = pwr;
        flag_last_zero   = flag;
        execute_from_ram = efr;
        #1;
    endtask

    initial begin
        reset_button = 1'b1;
        apply(3'd0, 32'd0, 32'd0, 8'd0, 16'd10, 1'b1, 1'b0, 1'b0);
        chk("rst_halted", {31'd0, halted}, 32'd0);
        chk("rst_pc_next", {16'd0, pc_next}, 32'h44);
        @(negedge clk);
        reset_button = 1'b0;

        apply(3'd0, 32'd0, 32'd99, 8'd15, 16'd10, 1'b1, 1'b0, 1'b0);
        chk("nop_pc_next", {16'd0, pc_next}, 32'd14);
        chk("nop_strobes", {30'd0, ram_is_write, output_is_write}, 32'd0);
        chk("nop_pwr", {31'd0, is_powered_on_new}, 32'd1);

        apply(3'd1, 32'd0, 32'd99, 8'd15, 16'd10, 1'b1, 1'b0, 1'b0);
        chk("rdir_addr", {16'd0, ram_address}, 32'd15);
        chk("rdir_data", ram_in, 32'd99);
        chk("rdir_strobes", {30'd0, ram_is_write, output_is_write}, 32'b10);
        chk("rdir_pc_next", {16'd0, pc_next}, 32'd14);

        apply(3'd2, 32'd0, 32'd99, 8'd15, 16'd10, 1'b1, 1'b0, 1'b0);
        chk("out_addr", {24'd0, output_devices_address}, 32'd15);
        chk("out_data", output_devices_value, 32'd99);
        chk("out_strobes", {30'd0, ram_is_write, output_is_write}, 32'b01);

        apply(3'd3, 32'h1234_0061, 32'd99, 8'd15, 16'd10, 1'b1, 1'b0, 1'b0);
        chk("rind_addr", {16'd0, ram_address}, 32'd97);
        chk("rind_data", ram_in, 32'd99);
        chk("rind_strobes", {30'd0, ram_is_write, output_is_write}, 32'b10);

        apply(3'd4, 32'd0, 32'hABCD_0063, 8'd15, 16'd10, 1'b1, 1'b0, 1'b0);
        chk("jmp_pc_next", {16'd0, pc_next}, 32'd99);
        apply(3'd5, 32'd0, 32'd99, 8'd15, 16'd10, 1'b1, 1'b1, 1'b0);
        chk("jz_taken", {16'd0, pc_next}, 32'd99);
        apply(3'd5, 32'd0, 32'd99, 8'd15, 16'd10, 1'b1, 1'b0, 1'b0);
        chk("jz_not_taken", {16'd0, pc_next}, 32'd14);
        apply(3'd6, 32'd0, 32'd99, 8'd15, 16'd10, 1'b1, 1'b0, 1'b0);
        chk("jnz_taken", {16'd0, pc_next}, 32'd99);
        apply(3'd6, 32'd0, 32'd99, 8'd15, 16'd10, 1'b1, 1'b1, 1'b0);
        chk("jnz_not_taken", {16'd0, pc_next}, 32'd14);
        apply(3'd0, 32'd0, 32'd99, 8'd15, 16'hFFFC, 1'b1, 1'b0, 1'b0);
        chk("pc_wrap", {16'd0, pc_next}, 32'd0);

        // Powered-off HLT must not set halted.
        apply(3'd7, 32'd0, 32'd99, 8'd15, 16'd10, 1'b0, 1'b0, 1'b1);
        chk("off_hlt_pwr", {31'd0, is_powered_on_new}, 32'd0);
        @(posedge clk); #1;
        chk("off_hlt_no_halt", {31'd0, halted}, 32'd0);

        apply(3'd7, 32'd0, 32'd99, 8'd15, 16'd10, 1'b1, 1'b0, 1'b1);
        chk("hlt_pwr_new", {31'd0, is_powered_on_new}, 32'd0);
        chk("hlt_efr_new", {31'd0, execute_from_ram_new}, 32'd1);
        chk("hlt_pc_next", {16'd0, pc_next}, 32'd10);
        chk("hlt_before_edge", {31'd0, halted}, 32'd0);
        @(posedge clk); #1;
        chk("hlt_after_edge", {31'd0, halted}, 32'd1);

        apply(3'd0, 32'd0, 32'd99, 8'd15, 16'd10, 1'b1, 1'b0, 1'b0);
        @(posedge clk); #1;
        chk("halt_sticky", {31'd0, halted}, 32'd1);

        apply(3'd0, 32'd0, 32'd99, 8'd15, 16'd10, 1'b0, 1'b0, 1'b1);
        reset_button = 1'b1;
        #1;
        chk("rst2_pc_next", {16'd0, pc_next}, 32'h44);
        chk("rst2_pwr_new", {31'd0, is_powered_on_new}, 32'd1);
        chk("rst2_efr_new", {31'd0, execute_from_ram_new}, 32'd0);
        chk("rst2_strobes", {30'd0, ram_is_write, output_is_write}, 32'd0);
        chk("rst2_halted_async", {31'd0, halted}, 32'd0);
        chk("rst2_ram_addr", {16'd0, ram_address}, 32'd15);

        apply(3'd7, 32'd0, 32'd99, 8'd15, 16'd10, 1'b1, 1'b0, 1'b1);
        chk("rst_over_hlt_pwr", {31'd0, is_powered_on_new}, 32'd1);
        chk("rst_over_hlt_pc", {16'd0, pc_next}, 32'h44);
        @(negedge clk);
        mblock_s3    = 3'd0;
        reset_button = 1'b0;

        apply(3'd1, 32'd0, 32'd99, 8'd15, 16'd10, 1'b0, 1'b0, 1'b1);
        chk("off_ram_strobe", {31'd0, ram_is_write}, 32'd0);
        chk("off_pc_next", {16'd0, pc_next}, 32'd10);
        chk("off_efr_pass", {31'd0, execute_from_ram_new}, 32'd1);
        apply(3'd2, 32'd0, 32'd99, 8'd15, 16'd10, 1'b0, 1'b0, 1'b0);
        chk("off_out_strobe", {31'd0, output_is_write}, 32'd0);
        apply(3'd4, 32'd0, 32'd99, 8'd15, 16'd10, 1'b0, 1'b0, 1'b0);
        chk("off_jmp_hold", {16'd0, pc_next}, 32'd10);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/stage3_writeback.md
# stage3_writeback

Third pipeline stage of the emulator core: write-back and next-state. It consumes the decoded micro-block selector and operand values from stage 2 and produces four things: RAM write requests, output-device write requests, the next program counter, and the next power/execution-mode flags. The datapath outputs are combinational and are latched by the core's state registers. The block also holds one registered halt status bit.

## Interface
Parameters:
- RESET_PC, 16'h0044, program counter loaded on reset.
- PC_STEP, 4, increment applied for sequential flow.

Ports:
- clk  input  1  core clock; used only by the halt status register.
- reset_button  input  1  reset, asynchronous, active-high. Forces the reset values listed below on all outputs and clears `halted`.
- mblock_s3  input  3  stage-3 micro-operation selector.
- vrw_value  input  32  read/write operand value; supplies the indirect address in mode 3.
- vw_value  input  32  value to write; also the jump target.
- vrw_source  input  8  direct address for RAM and output devices.
- pc  input  16  current program counter.
- is_powered_on  input  1  current power state.
- flag_last_zero  input  1  zero flag from the last ALU operation.
- execute_from_ram  input  1  current execution-source flag.
- output_devices_value  output  32  data for an output device.
- output_devices_address  output  8  output device index.
- ram_address  output  16  RAM write address.
- ram_in  output  32  RAM write data.
- ram_is_write  output  1  RAM write strobe.
- output_is_write  output  1  output-device write strobe.
- pc_next  output  16  next program counter.
- execute_from_ram_new  output  1  next execution-source flag.
- is_powered_on_new  output  1  next power state.
- halted  output  1  registered; set by an executed HLT.

## Operation
Defaults, applied unless a mode below overrides them:
- ram_address = {8'h00, vrw_source}
- ram_in = vw_value
- output_devices_address = vrw_source
- output_devices_value = vw_value
- both write strobes = 0
- pc_next = pc + PC_STEP, modulo 2^16
- is_powered_on_new = is_powered_on
- execute_from_ram_new = execute_from_ram

mblock_s3 decode:
- 0 NOP: defaults only.
- 1 RAM_WRITE_DIRECT: ram_is_write = 1; address = {8'h00, vrw_source}.
- 2 OUT_WRITE: output_is_write = 1.
- 3 RAM_WRITE_INDIRECT: ram_is_write = 1; ram_address = vrw_value[15:0].
- 4 JMP: pc_next = vw_value[15:0].
- 5 JZ: pc_next = vw_value[15:0] if flag_last_zero = 1, else pc + 4.
- 6 JNZ: pc_next = vw_value[15:0] if flag_last_zero = 0, else pc + 4.
- 7 HLT: is_powered_on_new = 0; pc_next = pc (hold); execute_from_ram_new passes through unchanged.

Powered-off rule: when is_powered_on = 0 and reset_button = 0:
- both write strobes = 0
- pc_next = pc
- is_powered_on_new = 0
- execute_from_ram_new passes through

Reset rule: reset_button = 1 overrides everything, including the powered-off rule and mode 7:
- pc_next = RESET_PC
- is_powered_on_new = 1
- execute_from_ram_new = 0
- both write strobes = 0
- address/data outputs keep their default values

## Timing
- All outputs except `halted` are purely combinational from the inputs, with zero-cycle latency. They are valid within the same cycle and must settle before the next clk rising edge.
- `halted` register:
  - Reset value 0.
  - Asynchronously cleared while reset_button = 1.
  - On a clk rising edge it becomes 1 when mblock_s3 = 7 and is_powered_on = 1.
  - It stays 1 until reset.
- Write strobes are single-cycle levels; the RAM and device blocks sample them on the clk rising edge.
- Truncation: jump targets and indirect addresses use bits [15:0] and ignore the upper bits. PC increment wraps 16'hFFFC to 16'h0000.

## Test plan
- pc = 10, powered on, mblock_s3 = 0 -> pc_next = 14, ram_is_write = 0, output_is_write = 0.
- mblock_s3 = 1, vw_value = 99, vrw_source = 15 -> ram_address = 15, ram_in = 99, ram_is_write = 1, output_is_write = 0, pc_next = 14.
- Mode 2 with the same inputs -> output_devices_address = 15, output_devices_value = 99, output_is_write = 1, ram_is_write = 0. Mode 3 with vrw_value = 97 -> ram_address = 97, ram_in = 99, ram_is_write = 1.
- Jumps with vw_value = 99, pc = 10:
  - Mode 4 -> pc_next = 99.
  - Mode 5: flag = 1 -> 99; flag = 0 -> 14.
  - Mode 6: flag = 0 -> 99; flag = 1 -> 14.
  - pc = 16'hFFFC, mode 0 -> pc_next = 0.
- Mode 7, execute_from_ram = 1 -> is_powered_on_new = 0, execute_from_ram_new = 1, pc_next = 10; `halted` = 1 after the next clk edge.
- reset_button = 1, is_powered_on = 0, mode 0 -> pc_next = 16'h0044, is_powered_on_new = 1, execute_from_ram_new = 0, strobes 0, `halted` cleared immediately without a clock. Powered off with no reset, mode 1 -> ram_is_write = 0, pc_next = pc.
